logic_unit_pipe: RTL and testbench

//  Parametrised, pipelined successor to the 4-bit combinational logic unit.

---
 rtl/logic_unit_pipe_if.sv | 30 +++
 rtl/logic_unit_pipe.sv | 136 +++++++++++++
 tb/tb_logic_unit_pipe.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_pipe_if.sv
// Streaming operand/result bus for logic_unit_pipe: operand handshake in,
// result handshake out, plus the transfer counter and result flags.
interface logic_unit_pipe_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned COUNT_W = 16
);
  logic               valid_in;
  logic               ready_out;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic [2:0]         opcode_in;
  logic [WIDTH-1:0]   result_out;
  logic               valid_out;
  logic               ready_in;
  logic [COUNT_W-1:0] count_out;
  logic               zero_out;
  logic               parity_out;

  // Producer/consumer side
  modport master (
    output valid_in, a_in, b_in, opcode_in, ready_in,
    input  ready_out, result_out, valid_out, count_out, zero_out, parity_out
  );

  // Logic unit side
  modport slave (
    input  valid_in, a_in, b_in, opcode_in, ready_in,
    output ready_out, result_out, valid_out, count_out, zero_out, parity_out
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Pipelined 8-op bitwise logic unit with STAGES valid/ready register slices.
// Define LU_FLAGS_EN to carry zero/parity flags alongside each result.
module logic_unit_pipe #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned STAGES  = 2,
  parameter int unsigned COUNT_W = 16
) (
  input logic               clk_in,
  input logic               reset_in,
  logic_unit_pipe_if.slave  bus
);

  localparam int unsigned LAST = STAGES - 1;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOTA = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_PASA = 3'b111
  } op_e;

  logic [STAGES-1:0][WIDTH-1:0] data_q, data_d;
  logic [STAGES-1:0]            vld_q, vld_d;
  logic [COUNT_W-1:0]           count_q, count_d;

  logic [WIDTH-1:0]             alu_c;
  logic [STAGES:0]              load_c;
  logic [STAGES-1:0]            hand_c;
  logic                         in_xfer_c;

  // Operation decode on the raw operands
  always_comb begin
    alu_c = '0;
    case (op_e'(bus.opcode_in))
      OP_AND:  alu_c = bus.a_in & bus.b_in;
      OP_OR:   alu_c = bus.a_in | bus.b_in;
      OP_XOR:  alu_c = bus.a_in ^ bus.b_in;
      OP_NOTA: alu_c = ~bus.a_in;
      OP_NAND: alu_c = ~(bus.a_in & bus.b_in);
      OP_NOR:  alu_c = ~(bus.a_in | bus.b_in);
      OP_XNOR: alu_c = ~(bus.a_in ^ bus.b_in);
      OP_PASA: alu_c = bus.a_in;
      default: alu_c = '0;
    endcase
  end

  // Backpressure chain: load_c[STAGES] is the downstream sink, so a stage can
  // load whenever it is empty or is emptying into a stage that loads.
  always_comb begin
    load_c         = '0;
    hand_c         = '0;
    load_c[STAGES] = bus.ready_in;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      hand_c[k] = vld_q[k] && load_c[k+1];
      load_c[k] = !vld_q[k] || hand_c[k];
    end
    in_xfer_c = bus.valid_in && load_c[0];
  end

  // Stage advance and transfer counter
  always_comb begin
    vld_d   = vld_q;
    data_d  = data_q;
    count_d = count_q;
    if (load_c[0]) begin
      vld_d[0] = in_xfer_c;
      if (in_xfer_c) data_d[0] = alu_c;
    end
    for (int k = 1; k < int'(STAGES); k++) begin
      if (load_c[k]) begin
        vld_d[k] = hand_c[k-1];
        if (hand_c[k-1]) data_d[k] = data_q[k-1];
      end
    end
    if (hand_c[LAST]) count_d = count_q + COUNT_W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      vld_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

`ifdef LU_FLAGS_EN
  logic [STAGES-1:0] zero_q, zero_d;
  logic [STAGES-1:0] par_q, par_d;

  // Flags are derived once at entry and then ride along with their result
  always_comb begin
    zero_d = zero_q;
    par_d  = par_q;
    if (in_xfer_c) begin
      zero_d[0] = (alu_c == '0);
      par_d[0]  = ^alu_c;
    end
    for (int k = 1; k < int'(STAGES); k++) begin
      if (load_c[k] && hand_c[k-1]) begin
        zero_d[k] = zero_q[k-1];
        par_d[k]  = par_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      zero_q <= '0;
      par_q  <= '0;
    end else begin
      zero_q <= zero_d;
      par_q  <= par_d;
    end
  end

  assign bus.zero_out   = zero_q[LAST];
  assign bus.parity_out = par_q[LAST];
`else
  assign bus.zero_out   = 1'b0;
  assign bus.parity_out = 1'b0;
`endif

  assign bus.ready_out  = load_c[0];
  assign bus.result_out = data_q[LAST];
  assign bus.valid_out  = vld_q[LAST];
  assign bus.count_out  = count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomised bench for logic_unit_pipe: a FIFO-level reference model with
// per-item acceptance timestamps predicts ready/valid/result/count each cycle.
`timescale 1ns/1ps
module tb_logic_unit_pipe;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned STAGES    = 2;
  localparam int unsigned COUNT_W   = 16;
  localparam int unsigned COUNT_W_S = 4;

  logic clk_in = 1'b0;
  logic reset_in;
  always #5 clk_in = ~clk_in;

  logic_unit_pipe_if #(.WIDTH(WIDTH), .COUNT_W(COUNT_W))   lu();
  logic_unit_pipe_if #(.WIDTH(WIDTH), .COUNT_W(COUNT_W_S)) lu_s();

  logic_unit_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .COUNT_W(COUNT_W)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .bus(lu.slave));

  logic_unit_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .COUNT_W(COUNT_W_S)) dut_s (
    .clk_in(clk_in), .reset_in(reset_in), .bus(lu_s.slave));

  assign lu_s.valid_in  = lu.valid_in;
  assign lu_s.a_in      = lu.a_in;
  assign lu_s.b_in      = lu.b_in;
  assign lu_s.opcode_in = lu.opcode_in;
  assign lu_s.ready_in  = lu.ready_in;

  typedef struct {
    logic [WIDTH-1:0] res;
    int unsigned      acc;
  } item_t;

  item_t            q[$];
  logic [WIDTH-1:0] t2_log[$];
  bit               log_en = 1'b0;
  bit               saw_wrap = 1'b0;
  int unsigned      prev_cnt_s = 0;
  int unsigned      cyc = 0;
  int unsigned      cnt = 0;
  int unsigned      dut_acc = 0;
  int unsigned      checks = 0;
  int unsigned      errors = 0;

  function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~a;
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus with full model comparison
  task automatic step(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [2:0] op, input bit rdy);
    bit          exp_rdy;
    bit          exp_vld;
    item_t       it;
    int unsigned cs;
    @(negedge clk_in);
    lu.valid_in  = v;
    lu.a_in      = a;
    lu.b_in      = b;
    lu.opcode_in = op;
    lu.ready_in  = rdy;
    #1;
    exp_vld = (q.size() > 0) && ((cyc - q[0].acc) >= STAGES);
    exp_rdy = (q.size() < STAGES) || rdy;
    check("ready_out",   32'(lu.ready_out),   32'(exp_rdy));
    check("valid_out",   32'(lu.valid_out),   32'(exp_vld));
    check("valid_out_s", 32'(lu_s.valid_out), 32'(exp_vld));
    check("count_out",   32'(lu.count_out),   cnt % (32'd1 << COUNT_W));
    check("count_out_s", 32'(lu_s.count_out), cnt % (32'd1 << COUNT_W_S));
    cs = 32'(lu_s.count_out);
    if (prev_cnt_s == 15 && cs == 0) saw_wrap = 1'b1;
    prev_cnt_s = cs;
    if (exp_vld) begin
      check("result_out",   32'(lu.result_out),   32'(q[0].res));
      check("result_out_s", 32'(lu_s.result_out), 32'(q[0].res));
`ifdef LU_FLAGS_EN
      check("zero_out",   32'(lu.zero_out),   32'(q[0].res == '0));
      check("parity_out", 32'(lu.parity_out), 32'(^q[0].res));
`endif
    end
`ifndef LU_FLAGS_EN
    check("zero_out_off",   32'(lu.zero_out),   32'd0);
    check("parity_out_off", 32'(lu.parity_out), 32'd0);
`endif
    if (lu.valid_in && lu.ready_out) dut_acc++;
    if (exp_vld && rdy) begin
      if (log_en) t2_log.push_back(lu.result_out);
      void'(q.pop_front());
      cnt++;
    end
    if (v && exp_rdy) begin
      it.res = ref_op(op, a, b);
      it.acc = cyc;
      q.push_back(it);
    end
    @(posedge clk_in);
    cyc++;
  endtask

  task automatic rand_step(input bit v, input bit rdy);
    step(v, WIDTH'($urandom), WIDTH'($urandom), 3'($urandom_range(7)), rdy);
  endtask

  task automatic drain(input int unsigned bound);
    for (int unsigned i = 0; i < bound; i++) begin
      if (q.size() == 0 && !lu.valid_out) break;
      rand_step(1'b0, 1'b1);
    end
    #1;
    check("drain_valid", 32'(lu.valid_out), 32'd0);
  endtask

  task automatic do_reset(input int unsigned n);
    @(negedge clk_in);
    reset_in    = 1'b1;
    lu.valid_in = 1'b0;
    lu.ready_in = 1'b0;
    repeat (n) @(posedge clk_in);
    @(negedge clk_in);
    reset_in = 1'b0;
    q.delete();
    cnt        = 0;
    prev_cnt_s = 0;
    check("rst_valid",  32'(lu.valid_out),  32'd0);
    check("rst_result", 32'(lu.result_out), 32'd0);
    check("rst_count",  32'(lu.count_out),  32'd0);
    check("rst_ready",  32'(lu.ready_out),  32'd1);
    check("rst_zero",   32'(lu.zero_out),   32'd0);
    check("rst_parity", 32'(lu.parity_out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] t2_exp [8];
    t2_exp = '{8'h30, 8'hFC, 8'hCC, 8'h0F, 8'hCF, 8'h03, 8'h33, 8'hF0};
    reset_in     = 1'b1;
    lu.valid_in  = 1'b0;
    lu.ready_in  = 1'b0;
    lu.a_in      = '0;
    lu.b_in      = '0;
    lu.opcode_in = '0;

    // Reset held for two cycles
    do_reset(2);

    // Every opcode once on fixed operands
    log_en = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 8'hF0, 8'h3C, 3'(i), 1'b1);
    drain(10);
    log_en = 1'b0;
    check("t2_n_results", 32'(t2_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < t2_log.size(); i++)
      check($sformatf("t2_res%0d", i), 32'(t2_log[i]), 32'(t2_exp[i]));
    check("t2_count", 32'(lu.count_out), 32'd8);

    // Full backpressure: only STAGES ops fit
    dut_acc = 0;
    for (int i = 0; i < 4; i++) rand_step(1'b1, 1'b0);
    check("t3_accepted", dut_acc, 32'(STAGES));
    drain(10);

    // 100 beats, ready_in toggling, also exercising the narrow counter wrap
    do_reset(1);
    dut_acc  = 0;
    saw_wrap = 1'b0;
    for (int i = 0; i < 400 && dut_acc < 100; i++) rand_step(1'b1, 1'(i % 2));
    drain(20);
    check("t4_accepted", dut_acc, 32'd100);
    check("t4_count",    32'(lu.count_out),   32'd100);
    check("t4_count_s",  32'(lu_s.count_out), 32'd100 % 32'd16);
    check("t4_wrap",     32'(saw_wrap),       32'd1);

    // Reset with both stages full discards in-flight results
    rand_step(1'b1, 1'b0);
    rand_step(1'b1, 1'b0);
    do_reset(1);
    for (int i = 0; i < 4; i++) rand_step(1'b0, 1'b1);

    // Flag corner operands
    step(1'b1, 8'h55, 8'h55, 3'b010, 1'b1);
    step(1'b1, 8'h01, 8'h00, 3'b001, 1'b1);
    drain(10);

    // Free-running random traffic
    for (int i = 0; i < 400; i++)
      rand_step(1'($urandom_range(3) != 0), 1'($urandom_range(9) < 7));
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
